// File: rtl/uart_pkg.sv
// Shared types and defaults for the uart block and its transmit-side arbiter.
package uart_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_BUSY} uart_arb_state_t;

    localparam int UART_ARB_MAXPKT = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req scanning ptr+1, ptr+2, ... mod N_.
module rr_pick #(
    parameter int N_  = 4,
    parameter int PW_ = (N_ > 1) ? $clog2(N_) : 1
) (
    input  logic [N_-1:0]  req,
    input  logic [PW_-1:0] ptr,
    output logic [N_-1:0]  pick,
    output logic           any
);

    logic [PW_-1:0] idx;

    // The entry at ptr is visited last, so the most recently served requester loses ties
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int k = 1; k <= N_; k++) begin
            idx = PW_'((int'(ptr) + k) % N_);
            if (!any && req[idx]) begin
                pick[idx] = 1'b1;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of the uart transmit buffer write port between N_ byte streams.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_      = 4,
    parameter int DATA_   = 8,
    parameter int MAXPKT_ = UART_ARB_MAXPKT
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [N_-1:0]       req,
    input  logic [N_-1:0]       valid,
    input  logic [N_*DATA_-1:0] data,
    input  logic [N_-1:0]       last,
    output logic [N_-1:0]       ready,
    output logic [N_-1:0]       grant,
    output logic                tbwe,
    output logic [DATA_-1:0]    tbdin,
    input  logic                tbfull
);

    localparam int PW = $clog2(N_);
    localparam int CW = $clog2(MAXPKT_ + 1);

    uart_arb_state_t state;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   pick_idx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [N_-1:0]   pick;
    logic            any;
    logic            xfer;

    rr_pick #(
        .N_  (N_),
        .PW_ (PW)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_; i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
    end

    // Owner's stream is passed straight through so tbfull backpressure acts in the same cycle
    always_comb begin
        ready   = '0;
        tbwe    = 1'b0;
        tbdin   = '0;
        if (state == ARB_BUSY) begin
            ready[owner] = !tbfull;
            tbwe         = valid[owner] & !tbfull;
            tbdin        = data[int'(owner)*DATA_ +: DATA_];
        end
        xfer    = tbwe;
        cnt_nxt = cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state <= ARB_IDLE;
            grant <= '0;
            owner <= '0;
            ptr   <= PW'(N_ - 1);
            cnt   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any) begin
                        grant <= pick;
                        owner <= pick_idx;
                        cnt   <= '0;
                        state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (xfer) cnt <= cnt_nxt;
                    // A transfer always wins over an abort; a dropped req is only seen on an idle cycle
                    if ((xfer && (last[owner] || cnt_nxt == CW'(MAXPKT_))) ||
                        (!xfer && !req[owner])) begin
                        state <= ARB_IDLE;
                        grant <= '0;
                        ptr   <= owner;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a packet cap of 4 bytes.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int M = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   valid;
    logic [N-1:0]   last;
    logic [N-1:0]   ready;
    logic [N-1:0]   grant;
    logic [N*W-1:0] data;
    logic           tbwe;
    logic [W-1:0]   tbdin;
    logic           tbfull;

    uart_tx_arbiter #(
        .N_      (N),
        .DATA_   (W),
        .MAXPKT_ (M)
    ) dut (
        .clk    (clk),
        .rst_   (rst),
        .req    (req),
        .valid  (valid),
        .data   (data),
        .last   (last),
        .ready  (ready),
        .grant  (grant),
        .tbwe   (tbwe),
        .tbdin  (tbdin),
        .tbfull (tbfull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [W-1:0] src_data [N][16];
    logic         src_last [N][16];
    int           src_len  [N];
    int           src_pos  [N];
    logic [N-1:0] junk_v;

    logic [W-1:0] wr_q[$];
    int           wr_cyc[$];
    logic [N-1:0] gnt_q[$];
    int           gnt_cyc[$];
    logic [N-1:0] prev_grant;

    logic [W-1:0] exp_w[$];
    logic [N-1:0] exp_g[$];

    logic [N-1:0] s_grant;
    logic [N-1:0] s_ready;
    logic         s_tbwe;
    logic [W-1:0] s_tbdin;

    // Present each source's current byte; idle sources may show junk that must be ignored
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_pos[i] < src_len[i]) begin
                req[i]           = 1'b1;
                valid[i]         = 1'b1;
                data[i*W +: W]   = src_data[i][src_pos[i]];
                last[i]          = src_last[i][src_pos[i]];
            end else begin
                req[i]           = 1'b0;
                valid[i]         = junk_v[i];
                data[i*W +: W]   = junk_v[i] ? 8'hEE : 8'h00;
                last[i]          = junk_v[i];
            end
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
    endtask

    task automatic clear_logs();
        wr_q.delete();
        wr_cyc.delete();
        gnt_q.delete();
        gnt_cyc.delete();
        prev_grant = '0;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++) begin
            if (src_pos[i] < src_len[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Sample on the falling edge, then advance accepted sources just after the rising edge
    task automatic cycle();
        logic [N-1:0] acc;
        @(negedge clk);
        s_grant = grant;
        s_ready = ready;
        s_tbwe  = tbwe;
        s_tbdin = tbdin;
        for (int i = 0; i < N; i++) begin
            acc[i] = valid[i] & ready[i] & (src_pos[i] < src_len[i]);
        end
        if (tbwe) begin
            wr_q.push_back(tbdin);
            wr_cyc.push_back(cyc);
        end
        if (grant != '0 && prev_grant == '0) begin
            gnt_q.push_back(grant);
            gnt_cyc.push_back(cyc);
        end
        prev_grant = grant;
        checks++;
        if (!$onehot0(grant) || (ready & ~grant) != '0) begin
            errors++;
            $display("[TB] FAIL grant_ready_shape: got grant=%b ready=%b expected one-hot grant covering ready", grant, ready);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) src_pos[i]++;
        end
        cyc++;
        drive();
    endtask

    task automatic run_until_idle(input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            cycle();
            if (all_done() && s_grant == '0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got still busy expected idle within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        for (int k = 0; k < budget && wr_q.size() < n; k++) cycle();
        checks++;
        if (wr_q.size() < n) begin
            errors++;
            $display("[TB] FAIL %s_wait: got %0d writes expected %0d", name, wr_q.size(), n);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        tbfull = 1'b0;
        junk_v = '0;
        clear_sources();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        junk_v = '1;
        drive();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (grant !== '0 || ready !== '0 || tbwe !== 1'b0 || tbdin !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got grant=%b ready=%b tbwe=%b tbdin=%h expected all zero", grant, ready, tbwe, tbdin);
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        junk_v = '0;
        drive();
        clear_logs();
        cycle();
        cycle();
        checks++;
        if (s_grant !== '0 || s_tbwe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got grant=%b tbwe=%b expected 0000/0", s_grant, s_tbwe);
        end
    endtask

    task automatic test_single_packet();
        clear_logs();
        src_data[0][0] = 8'h41; src_last[0][0] = 1'b0;
        src_data[0][1] = 8'h42; src_last[0][1] = 1'b1;
        src_len[0] = 2;
        junk_v = 4'b0100;
        drive();
        cycle();
        checks++;
        if (s_grant !== '0 || s_tbwe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t1_arb_cycle: got grant=%b tbwe=%b expected 0000/0", s_grant, s_tbwe);
        end
        cycle();
        checks++;
        if (s_grant !== 4'b0001 || s_tbwe !== 1'b1 || s_tbdin !== 8'h41) begin
            errors++;
            $display("[TB] FAIL t1_first_byte: got grant=%b tbwe=%b tbdin=%h expected 0001/1/41", s_grant, s_tbwe, s_tbdin);
        end
        run_until_idle(20, "t1");
        junk_v = '0;
        drive();
        exp_w = '{8'h41, 8'h42};
        checks++;
        if (wr_q.size() != exp_w.size()) begin
            errors++;
            $display("[TB] FAIL t1_write_count: got %0d expected %0d", wr_q.size(), exp_w.size());
        end else begin
            for (int k = 0; k < exp_w.size(); k++) begin
                checks++;
                if (wr_q[k] !== exp_w[k]) begin
                    errors++;
                    $display("[TB] FAIL t1_write_%0d: got %h expected %h", k, wr_q[k], exp_w[k]);
                end
            end
            checks++;
            if (wr_cyc[1] - wr_cyc[0] != 1) begin
                errors++;
                $display("[TB] FAIL t1_back_to_back: got gap %0d expected 1", wr_cyc[1] - wr_cyc[0]);
            end
        end
        // Having just served requester 0, requester 1 must now win a tie against it
        clear_logs();
        src_data[0][0] = 8'h43; src_last[0][0] = 1'b1; src_len[0] = 1; src_pos[0] = 0;
        src_data[1][0] = 8'h44; src_last[1][0] = 1'b1; src_len[1] = 1; src_pos[1] = 0;
        drive();
        run_until_idle(20, "t1_ptr");
        checks++;
        if (gnt_q.size() != 2 || gnt_q[0] !== 4'b0010 || gnt_q[1] !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL t1_ptr_order: got %0d grants first=%b expected 0010 then 0001", gnt_q.size(), (gnt_q.size() > 0) ? gnt_q[0] : 4'b0000);
        end
        checks++;
        if (wr_q.size() != 2 || wr_q[0] !== 8'h44 || wr_q[1] !== 8'h43) begin
            errors++;
            $display("[TB] FAIL t1_ptr_bytes: got %0d writes first=%h expected 44,43", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 8'h00);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        src_data[0][0] = 8'hA0; src_last[0][0] = 1'b1;
        src_data[0][1] = 8'hA1; src_last[0][1] = 1'b1;
        src_len[0] = 2;
        src_data[1][0] = 8'hB0; src_last[1][0] = 1'b1; src_len[1] = 1;
        src_data[2][0] = 8'hC0; src_last[2][0] = 1'b1; src_len[2] = 1;
        src_data[3][0] = 8'hD0; src_last[3][0] = 1'b1; src_len[3] = 1;
        drive();
        run_until_idle(40, "t2");
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_w = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1};
        checks++;
        if (gnt_q.size() != exp_g.size()) begin
            errors++;
            $display("[TB] FAIL t2_grant_count: got %0d expected %0d", gnt_q.size(), exp_g.size());
        end else begin
            for (int k = 0; k < exp_g.size(); k++) begin
                checks++;
                if (gnt_q[k] !== exp_g[k]) begin
                    errors++;
                    $display("[TB] FAIL t2_grant_%0d: got %b expected %b", k, gnt_q[k], exp_g[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (gnt_cyc[k] - gnt_cyc[k-1] != 2) begin
                        errors++;
                        $display("[TB] FAIL t2_gap_%0d: got %0d cycles expected 2", k, gnt_cyc[k] - gnt_cyc[k-1]);
                    end
                end
            end
        end
        checks++;
        if (wr_q.size() != exp_w.size()) begin
            errors++;
            $display("[TB] FAIL t2_write_count: got %0d expected %0d", wr_q.size(), exp_w.size());
        end else begin
            for (int k = 0; k < exp_w.size(); k++) begin
                checks++;
                if (wr_q[k] !== exp_w[k]) begin
                    errors++;
                    $display("[TB] FAIL t2_write_%0d: got %h expected %h", k, wr_q[k], exp_w[k]);
                end
            end
        end
    endtask

    task automatic test_maxpkt();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            src_data[2][k] = 8'(k);
            src_last[2][k] = (k == 9);
        end
        src_len[2] = 10;
        src_data[0][0] = 8'hA0; src_last[0][0] = 1'b1;
        src_data[0][1] = 8'hA1; src_last[0][1] = 1'b1;
        src_len[0] = 2;
        drive();
        run_until_idle(80, "t3");
        exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0100};
        exp_w = '{8'hA0, 8'h00, 8'h01, 8'h02, 8'h03, 8'hA1, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        checks++;
        if (gnt_q.size() != exp_g.size()) begin
            errors++;
            $display("[TB] FAIL t3_grant_count: got %0d expected %0d", gnt_q.size(), exp_g.size());
        end else begin
            for (int k = 0; k < exp_g.size(); k++) begin
                checks++;
                if (gnt_q[k] !== exp_g[k]) begin
                    errors++;
                    $display("[TB] FAIL t3_grant_%0d: got %b expected %b", k, gnt_q[k], exp_g[k]);
                end
            end
        end
        checks++;
        if (wr_q.size() != exp_w.size()) begin
            errors++;
            $display("[TB] FAIL t3_write_count: got %0d expected %0d", wr_q.size(), exp_w.size());
        end else begin
            for (int k = 0; k < exp_w.size(); k++) begin
                checks++;
                if (wr_q[k] !== exp_w[k]) begin
                    errors++;
                    $display("[TB] FAIL t3_write_%0d: got %h expected %h", k, wr_q[k], exp_w[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        src_data[1][0] = 8'h11; src_last[1][0] = 1'b0;
        src_data[1][1] = 8'h22; src_last[1][1] = 1'b0;
        src_data[1][2] = 8'h33; src_last[1][2] = 1'b1;
        src_len[1] = 3;
        src_pos[1] = 0;
        drive();
        wait_writes(1, 10, "t4");
        tbfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++;
            if (s_ready !== '0 || s_tbwe !== 1'b0 || s_grant !== 4'b0010) begin
                errors++;
                $display("[TB] FAIL t4_hold_%0d: got ready=%b tbwe=%b grant=%b expected 0000/0/0010", k, s_ready, s_tbwe, s_grant);
            end
        end
        tbfull = 1'b0;
        run_until_idle(20, "t4");
        exp_w = '{8'h11, 8'h22, 8'h33};
        checks++;
        if (wr_q.size() != exp_w.size()) begin
            errors++;
            $display("[TB] FAIL t4_write_count: got %0d expected %0d", wr_q.size(), exp_w.size());
        end else begin
            for (int k = 0; k < exp_w.size(); k++) begin
                checks++;
                if (wr_q[k] !== exp_w[k]) begin
                    errors++;
                    $display("[TB] FAIL t4_write_%0d: got %h expected %h", k, wr_q[k], exp_w[k]);
                end
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        src_data[1][0] = 8'h51; src_last[1][0] = 1'b0;
        src_data[1][1] = 8'h52; src_last[1][1] = 1'b0;
        src_data[1][2] = 8'h53; src_last[1][2] = 1'b0;
        src_data[1][3] = 8'h54; src_last[1][3] = 1'b1;
        src_len[1] = 4;
        src_data[3][0] = 8'h71; src_last[3][0] = 1'b1;
        src_len[3] = 1;
        drive();
        wait_writes(2, 10, "t5");
        src_len[1] = 2;
        drive();
        cycle();
        checks++;
        if (s_grant !== 4'b0010 || s_tbwe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t5_drop_cycle: got grant=%b tbwe=%b expected 0010/0", s_grant, s_tbwe);
        end
        cycle();
        checks++;
        if (s_grant !== '0) begin
            errors++;
            $display("[TB] FAIL t5_idle: got grant=%b expected 0000", s_grant);
        end
        cycle();
        checks++;
        if (s_grant !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL t5_next_grant: got grant=%b expected 1000", s_grant);
        end
        run_until_idle(20, "t5");
        exp_w = '{8'h51, 8'h52, 8'h71};
        checks++;
        if (wr_q.size() != exp_w.size()) begin
            errors++;
            $display("[TB] FAIL t5_write_count: got %0d expected %0d", wr_q.size(), exp_w.size());
        end else begin
            for (int k = 0; k < exp_w.size(); k++) begin
                checks++;
                if (wr_q[k] !== exp_w[k]) begin
                    errors++;
                    $display("[TB] FAIL t5_write_%0d: got %h expected %h", k, wr_q[k], exp_w[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        src_data[0][0] = 8'h61; src_last[0][0] = 1'b0;
        src_data[0][1] = 8'h62; src_last[0][1] = 1'b0;
        src_data[0][2] = 8'h63; src_last[0][2] = 1'b0;
        src_data[0][3] = 8'h64; src_last[0][3] = 1'b1;
        src_len[0] = 4;
        drive();
        wait_writes(2, 10, "t6");
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== '0 || ready !== '0 || tbwe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL t6_async_drop: got grant=%b ready=%b tbwe=%b expected 0000/0000/0", grant, ready, tbwe);
        end
        clear_sources();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        cycle();
        checks++;
        if (wr_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL t6_no_extra_writes: got %0d writes expected 2", wr_q.size());
        end
        clear_logs();
        src_data[0][0] = 8'h65; src_last[0][0] = 1'b1; src_len[0] = 1;
        src_data[2][0] = 8'h66; src_last[2][0] = 1'b1; src_len[2] = 1;
        drive();
        run_until_idle(20, "t6");
        checks++;
        if (gnt_q.size() < 1 || gnt_q[0] !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL t6_first_grant: got %b expected 0001", (gnt_q.size() > 0) ? gnt_q[0] : 4'b0000);
        end
        checks++;
        if (wr_q.size() != 2 || wr_q[0] !== 8'h65 || wr_q[1] !== 8'h66) begin
            errors++;
            $display("[TB] FAIL t6_bytes: got %0d writes first=%h expected 65,66", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 8'h00);
        end
    endtask

    initial begin
        rst        = 1'b1;
        tbfull     = 1'b0;
        junk_v     = '0;
        prev_grant = '0;
        clear_sources();
        drive();
        test_reset();
        test_single_packet();
        test_rotation();
        test_maxpkt();
        test_backpressure();
        test_abort();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
